// File: rtl/v2f_divmod_seq_if.sv
// v2f_divmod_seq_if: operand/result handshake bundle for the sequential divide/modulo unit.
interface v2f_divmod_seq_if #(parameter int WIDTH = 32);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      quo;
   logic [31:0]      rem;
   logic             dbz;
   modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, quo, rem, dbz);
   modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, quo, rem, dbz);
endinterface

// File: rtl/v2f_divmod_seq.sv
// v2f_divmod_seq: restoring divider giving truncating quotient and dividend-signed remainder, x/0 = 0.
module v2f_divmod_seq #(
   parameter int WIDTH  = 32,
   parameter bit SIGNED = 1'b1
) (
   input logic             clk,
   input logic             rst_n,
   v2f_divmod_seq_if.slave io
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
   state_t           st_q, st_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d, r_q, r_d, qn, rn;
   logic [WIDTH:0]   d_q, d_d, bx, t;
   logic [CW-1:0]    c_q, c_d;
   logic             sa_q, sa_d, sb_q, sb_d, dbz_q, dbz_d, ge;
   logic [31:0]      quo_q, quo_d, rem_q, rem_d;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q  <= IDLE;
         a_q   <= '0;
         b_q   <= '0;
         n_q   <= '0;
         r_q   <= '0;
         d_q   <= '0;
         c_q   <= '0;
         sa_q  <= 1'b0;
         sb_q  <= 1'b0;
         dbz_q <= 1'b0;
         quo_q <= '0;
         rem_q <= '0;
      end else begin
         st_q  <= st_d;
         a_q   <= a_d;
         b_q   <= b_d;
         n_q   <= n_d;
         r_q   <= r_d;
         d_q   <= d_d;
         c_q   <= c_d;
         sa_q  <= sa_d;
         sb_q  <= sb_d;
         dbz_q <= dbz_d;
         quo_q <= quo_d;
         rem_q <= rem_d;
      end
   end
   // n_q holds the dividend magnitude and collects quotient bits as it shifts out
   always_comb begin
      st_d  = st_q;
      a_d   = a_q;
      b_d   = b_q;
      n_d   = n_q;
      r_d   = r_q;
      d_d   = d_q;
      c_d   = c_q;
      sa_d  = sa_q;
      sb_d  = sb_q;
      dbz_d = dbz_q;
      quo_d = quo_q;
      rem_d = rem_q;
      bx    = {sb_q & b_q[WIDTH-1], b_q};
      t     = {r_q, n_q[WIDTH-1]};
      ge    = t >= d_q;
      qn    = (sa_q ^ sb_q) ? -n_q : n_q;
      rn    = sa_q ? -r_q : r_q;
      case (st_q)
         IDLE: if (io.in_valid) begin
            a_d  = io.a;
            b_d  = io.b;
            sa_d = SIGNED & io.a[WIDTH-1];
            sb_d = SIGNED & io.b[WIDTH-1];
            st_d = PREP;
         end
         PREP: begin
            n_d  = (b_q == '0) ? '0 : (sa_q ? -a_q : a_q);
            d_d  = sb_q ? -bx : bx;
            r_d  = '0;
            c_d  = CW'(WIDTH - 1);
            st_d = (b_q == '0) ? FIX : ITER;
         end
         ITER: begin
            r_d  = ge ? WIDTH'(t - d_q) : t[WIDTH-1:0];
            n_d  = {n_q[WIDTH-2:0], ge};
            c_d  = c_q - 1'b1;
            st_d = (c_q == '0) ? FIX : ITER;
         end
         FIX: begin
            quo_d = SIGNED ? 32'(signed'(qn)) : 32'(qn);
            rem_d = SIGNED ? 32'(signed'(rn)) : 32'(rn);
            dbz_d = b_q == '0;
            st_d  = DONE;
         end
         DONE: st_d = io.out_ready ? IDLE : DONE;
         default: st_d = IDLE;
      endcase
   end
   assign io.in_ready  = st_q == IDLE;
   assign io.out_valid = st_q == DONE;
   assign io.quo       = quo_q;
   assign io.rem       = rem_q;
   assign io.dbz       = dbz_q;
endmodule

// File: tb/tb_v2f_divmod_seq.sv
// tb_v2f_divmod_seq: directed checks of a signed 32-bit and an unsigned 8-bit divider instance.
module tb_v2f_divmod_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   seen;
   always #5 clk = ~clk;
   v2f_divmod_seq_if #(.WIDTH(32)) i32 ();
   v2f_divmod_seq_if #(.WIDTH(8))  i8 ();
   v2f_divmod_seq #(.WIDTH(32), .SIGNED(1'b1)) u32 (.clk(clk), .rst_n(rst_n), .io(i32));
   v2f_divmod_seq #(.WIDTH(8),  .SIGNED(1'b0)) u8  (.clk(clk), .rst_n(rst_n), .io(i8));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic go(input bit sel, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      if (sel) begin
         chk("acc_rdy8", 32'(i8.in_ready), 32'd1);
         i8.a = a[7:0];
         i8.b = b[7:0];
         i8.in_valid = 1'b1;
      end else begin
         chk("acc_rdy32", 32'(i32.in_ready), 32'd1);
         i32.a = a;
         i32.b = b;
         i32.in_valid = 1'b1;
      end
      step();
      i8.in_valid = 1'b0;
      i32.in_valid = 1'b0;
   endtask
   task automatic fin(input bit sel, input int lat, input logic [31:0] eq, input logic [31:0] er,
                      input logic ed, input string tag);
      int n = 0;
      while (!(sel ? i8.out_valid : i32.out_valid) && n < 100) begin
         step();
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'(lat));
      chk({tag, "_quo"}, sel ? i8.quo : i32.quo, eq);
      chk({tag, "_rem"}, sel ? i8.rem : i32.rem, er);
      chk({tag, "_dbz"}, 32'(sel ? i8.dbz : i32.dbz), 32'(ed));
   endtask
   initial begin
      i32.in_valid = 1'b0; i32.a = '0; i32.b = '0; i32.out_ready = 1'b1;
      i8.in_valid  = 1'b0; i8.a  = '0; i8.b  = '0; i8.out_ready  = 1'b1;
      step();
      step();
      chk("rst_in_ready", 32'(i32.in_ready), 32'd1);
      chk("rst_out_valid", 32'(i32.out_valid), 32'd0);
      chk("rst_quo", i32.quo, 32'd0);
      chk("rst_rem", i32.rem, 32'd0);
      chk("rst_dbz", 32'(i32.dbz), 32'd0);
      chk("rst_in_ready8", 32'(i8.in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      go(0, 32'hFFFF_FFF9, 32'd2);
      fin(0, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "m7d2");
      step();
      go(0, 32'd7, 32'hFFFF_FFFE);
      fin(0, 34, 32'hFFFF_FFFD, 32'd1, 1'b0, "7dm2");
      step();
      go(0, 32'h8000_0000, 32'hFFFF_FFFF);
      fin(0, 34, 32'h8000_0000, 32'd0, 1'b0, "minm1");
      step();
      go(0, 32'hFFFF_FF9C, 32'd7);
      fin(0, 34, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, "m100d7");
      step();
      go(0, 32'd123, 32'd0);
      fin(0, 2, 32'd0, 32'd0, 1'b1, "dbz");
      step();
      go(1, 32'hFF, 32'h10);
      fin(1, 10, 32'h0000_000F, 32'h0000_000F, 1'b0, "u8ff");
      step();
      go(1, 32'h80, 32'h07);
      fin(1, 10, 32'd18, 32'd2, 1'b0, "u8_128d7");
      step();
      i32.out_ready = 1'b0;
      go(0, 32'd100, 32'd7);
      fin(0, 34, 32'd14, 32'd2, 1'b0, "bp");
      repeat (5) begin
         step();
         chk("bp_valid", 32'(i32.out_valid), 32'd1);
         chk("bp_quo", i32.quo, 32'd14);
         chk("bp_rem", i32.rem, 32'd2);
         chk("bp_in_ready", 32'(i32.in_ready), 32'd0);
      end
      i32.out_ready = 1'b1;
      step();
      chk("bp_rel_in_ready", 32'(i32.in_ready), 32'd1);
      chk("bp_rel_valid", 32'(i32.out_valid), 32'd0);
      go(0, 32'd9, 32'd3);
      fin(0, 34, 32'd3, 32'd0, 1'b0, "9d3");
      step();
      go(0, 32'd1000, 32'd7);
      repeat (9) step();
      chk("mid_valid", 32'(i32.out_valid), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mr_in_ready", 32'(i32.in_ready), 32'd1);
      chk("mr_out_valid", 32'(i32.out_valid), 32'd0);
      chk("mr_quo", i32.quo, 32'd0);
      chk("mr_rem", i32.rem, 32'd0);
      chk("mr_dbz", 32'(i32.dbz), 32'd0);
      step();
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         step();
         if (i32.out_valid) seen++;
      end
      chk("mr_no_stale", 32'(seen), 32'd0);
      go(0, 32'd50, 32'd5);
      fin(0, 34, 32'd10, 32'd0, 1'b0, "50d5");
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
